// File: rtl/rf_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// rf_fifo_ctrl : FIFO controller around a 1-cycle-latency register-file macro
//                with a 2-entry output buffer that hides the read latency.
// Revision     : 1.0
// ============================================================================
module rf_fifo_ctrl #(
  parameter int DW        = 32,
  parameter int AW        = 7,
  parameter int AFULL_THR = 112
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_valid_i,
  input  logic [DW-1:0] push_data_i,
  output logic          push_ready_o,
  output logic          pop_valid_o,
  output logic [DW-1:0] pop_data_o,
  input  logic          pop_ready_i,
  output logic [AW+1:0] level_o,
  output logic          almost_full_o,
  input  logic [6:0]    cfg_ram_ctrl_i,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_wr_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          ram_re_o,
  output logic [AW-1:0] ram_rd_addr_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic [6:0]    ram_ctrl_o
);

  localparam logic [AW:0] c_depth     = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] c_afull_thr = (AW+1)'(AFULL_THR);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   rf_cnt_q, rf_cnt_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    obuf_cnt_q, obuf_cnt_d;
  logic [DW-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;
  logic [6:0]    ram_ctrl_q, ram_ctrl_d;

  logic       w_active, w_push_fire, w_pop_fire, w_rd_fire;
  logic [2:0] w_pending;
  logic [1:0] w_obuf_after_pop;

  always_comb begin
    w_active      = ~rst & ~flush_i;
    push_ready_o  = w_active & (rf_cnt_q < c_depth);
    pop_valid_o   = ~rst & (obuf_cnt_q != 2'd0);
    pop_data_o    = obuf0_q;
    almost_full_o = ~rst & (rf_cnt_q >= c_afull_thr);
    level_o       = rst ? '0 : ({1'b0, rf_cnt_q} + (AW+2)'(inflight_q) + (AW+2)'(obuf_cnt_q));
    ram_ctrl_o    = ram_ctrl_q;

    w_push_fire = push_valid_i & push_ready_o;
    w_pop_fire  = pop_valid_o & pop_ready_i;
    // Words already owed to the output buffer after this cycle's pop; rf_cnt
    // only counts earlier writes, so the read never targets this cycle's write.
    w_pending   = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop_fire};
    w_rd_fire   = w_active & (rf_cnt_q != '0) & (w_pending < 3'd2);

    ram_we_o      = w_push_fire;
    ram_wr_addr_o = wr_ptr_q;
    ram_wdata_o   = push_data_i;
    ram_re_o      = w_rd_fire;
    ram_rd_addr_o = rd_ptr_q;

    wr_ptr_d   = wr_ptr_q + (AW)'(w_push_fire);
    rd_ptr_d   = rd_ptr_q + (AW)'(w_rd_fire);
    rf_cnt_d   = rf_cnt_q + (AW+1)'(w_push_fire) - (AW+1)'(w_rd_fire);
    inflight_d = w_rd_fire;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    ram_ctrl_d = cfg_ram_ctrl_i;

    w_obuf_after_pop = obuf_cnt_q - {1'b0, w_pop_fire};
    if (w_pop_fire) obuf0_d = obuf1_q;
    obuf_cnt_d = w_obuf_after_pop;
    if (inflight_q & w_active) begin
      if (w_obuf_after_pop == 2'd0) obuf0_d = ram_rdata_i;
      else                          obuf1_d = ram_rdata_i;
      obuf_cnt_d = w_obuf_after_pop + 2'd1;
    end

    // Flush drops the returning read data by clearing the in-flight bit.
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rf_cnt_d   = '0;
      inflight_d = 1'b0;
      obuf_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rf_cnt_q   <= '0;
      inflight_q <= 1'b0;
      obuf_cnt_q <= 2'd0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
      ram_ctrl_q <= 7'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rf_cnt_q   <= rf_cnt_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      ram_ctrl_q <= ram_ctrl_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rf_fifo_ctrl : scoreboard bench for rf_fifo_ctrl with a behavioural RF.
// Revision        : 1.0
// ============================================================================
module tb_rf_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst, flush_i, push_valid_i, pop_ready_i;
  logic [DW-1:0] push_data_i, pop_data_o, ram_wdata_o, ram_rdata_i;
  logic          push_ready_o, pop_valid_o, almost_full_o, ram_we_o, ram_re_o;
  logic [AW+1:0] level_o;
  logic [6:0]    cfg_ram_ctrl_i, ram_ctrl_o;
  logic [AW-1:0] ram_wr_addr_o, ram_rd_addr_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  rf_fifo_ctrl #(.DW(DW), .AW(AW), .AFULL_THR(112)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
    .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o), .pop_ready_i(pop_ready_i),
    .level_o(level_o), .almost_full_o(almost_full_o), .cfg_ram_ctrl_i(cfg_ram_ctrl_i),
    .ram_we_o(ram_we_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_re_o(ram_re_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rdata_i(ram_rdata_i),
    .ram_ctrl_o(ram_ctrl_o)
  );

  always #5 clk = ~clk;

  // Register-file macro: read data appears one cycle after ram_re_o, garbage otherwise.
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_wr_addr_o] <= ram_wdata_o;
    if (ram_re_o) ram_rdata_i <= mem[ram_rd_addr_o];
    else          ram_rdata_i <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !flush_i) begin
      if (push_valid_i && push_ready_o) exp_q.push_back(push_data_i);
      if (pop_valid_o && pop_ready_i) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 64'd1, 64'd0);
        else                   check_eq("sb_pop_data", pop_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    push_valid_i = 1'b0;
    pop_ready_i  = 1'b1;
    while (level_o != '0 && guard < 400) begin
      tick();
      guard++;
    end
    check_eq("drain_timeout", 64'(guard >= 400), 64'd0);
    check_eq("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    pop_ready_i = 1'b0;
  endtask

  task automatic do_flush();
    tick();
    flush_i = 1'b1; push_valid_i = 1'b0; pop_ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int k, pushes, pops, wraps;
    rst = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
    push_data_i = '0; cfg_ram_ctrl_i = 7'h55;
    tick(); tick();
    @(negedge clk);
    check_eq("rst_push_ready", push_ready_o, 0);
    check_eq("rst_pop_valid", pop_valid_o, 0);
    check_eq("rst_level", level_o, 0);
    check_eq("rst_we_re", {ram_we_o, ram_re_o}, 0);
    check_eq("rst_ram_ctrl", ram_ctrl_o, 7'h00);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_push_ready", push_ready_o, 1);
    check_eq("post_rst_afull", almost_full_o, 0);

    // Single word latency
    tick();
    push_valid_i = 1'b1; push_data_i = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("t0_we", ram_we_o, 1);
    check_eq("t0_wr_addr", ram_wr_addr_o, 0);
    check_eq("t0_wdata", ram_wdata_o, 32'hDEADBEEF);
    tick();
    push_valid_i = 1'b0;
    @(negedge clk);
    check_eq("t1_re", ram_re_o, 1);
    check_eq("t1_rd_addr", ram_rd_addr_o, 0);
    tick();
    @(negedge clk);
    check_eq("t2_pop_valid", pop_valid_o, 0);
    tick();
    @(negedge clk);
    check_eq("t3_pop_valid", pop_valid_o, 1);
    check_eq("t3_pop_data", pop_data_o, 32'hDEADBEEF);
    check_eq("t3_level", level_o, 1);
    drain();

    // Fill without popping
    k = 0;
    for (int i = 0; i < 135; i++) begin
      tick();
      push_valid_i = 1'b1; push_data_i = 32'hA000_0000 + i;
      @(negedge clk);
      if (k == 113) check_eq("afull_at_111", almost_full_o, 0);
      if (k == 114) check_eq("afull_at_112", almost_full_o, 1);
      if (push_valid_i && push_ready_o) k++;
    end
    check_eq("fill_accepted", k, 130);
    check_eq("fill_level", level_o, 130);
    check_eq("fill_push_ready", push_ready_o, 0);
    check_eq("fill_afull", almost_full_o, 1);
    tick();
    drain();

    // Streaming with pointer wrap
    do_flush();
    pushes = 0; pops = 0; wraps = 0;
    pop_ready_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push_valid_i = 1'b1; push_data_i = $urandom;
      @(negedge clk);
      if (push_valid_i && push_ready_o) pushes++;
      if (pop_valid_o && pop_ready_i) pops++;
      if (ram_we_o && ram_wr_addr_o == '0) wraps++;
      tick();
    end
    check_eq("stream_pushes", pushes, 300);
    check_eq("stream_pops", pops, 297);
    check_eq("stream_addr0_writes", wraps, 3);
    drain();

    // Flush with a read in flight
    do_flush();
    for (int i = 0; i < 6; i++) begin
      push_valid_i = 1'b1; push_data_i = 32'hF000_0000 + i;
      tick();
    end
    push_valid_i = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check_eq("pre_flush_level", level_o, 6);
    tick();
    pop_ready_i = 1'b1;
    tick();
    pop_ready_i = 1'b0; flush_i = 1'b1; push_valid_i = 1'b1; push_data_i = 32'h1234;
    @(negedge clk);
    check_eq("flush_held_level", level_o, 5);
    check_eq("flush_we_re", {ram_we_o, ram_re_o}, 0);
    check_eq("flush_push_ready", push_ready_o, 0);
    tick();
    flush_i = 1'b0; push_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("post_flush_level", level_o, 0);
    check_eq("post_flush_pop_valid", pop_valid_o, 0);
    tick();
    @(negedge clk);
    check_eq("post_flush_no_capture", {pop_valid_o, level_o}, 0);

    // Reset mid-stream
    for (int i = 0; i < 40; i++) begin
      tick();
      push_valid_i = 1'b1; push_data_i = 32'hB000_0000 + i;
    end
    tick();
    rst = 1'b1; push_valid_i = 1'b1; pop_ready_i = 1'b1;
    @(negedge clk);
    check_eq("midrst_outputs", {push_ready_o, pop_valid_o, almost_full_o, ram_we_o, ram_re_o}, 0);
    check_eq("midrst_level", level_o, 0);
    tick();
    rst = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("after_rst_level", level_o, 0);
    check_eq("after_rst_pop_valid", pop_valid_o, 0);
    check_eq("after_rst_ram_ctrl", ram_ctrl_o, 7'h00);
    tick();
    push_valid_i = 1'b1; push_data_i = 32'h1;
    tick();
    push_valid_i = 1'b0;
    tick();
    @(negedge clk);
    check_eq("rst_t2_pop_valid", pop_valid_o, 0);
    tick();
    @(negedge clk);
    check_eq("rst_t3_pop_valid", pop_valid_o, 1);
    check_eq("rst_t3_pop_data", pop_data_o, 32'h1);
    drain();

    // Config register under flush
    tick();
    cfg_ram_ctrl_i = 7'h2A; flush_i = 1'b1;
    @(negedge clk);
    check_eq("cfg_before", ram_ctrl_o, 7'h55);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check_eq("cfg_after", ram_ctrl_o, 7'h2A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
